// File: rtl/debug_pkg.sv
// Shared definitions for the debug unit: command bytes, timeout marker and
// the sequencer state encoding used by debug_unit_ctrl and dump_sequencer.
package debug_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [BYTE_W-1:0] CMD_RESET         = 8'h52;  // 'R'
    localparam logic [BYTE_W-1:0] CMD_STEP          = 8'h53;  // 'S'
    localparam logic [BYTE_W-1:0] CMD_RUN           = 8'h43;  // 'C'
    localparam logic [BYTE_W-1:0] DUMP_TIMEOUT_BYTE = 8'hEE;

    typedef enum logic [3:0] {
        IDLE,
        DECODE,
        DPRST,
        STEP,
        RUN,
        DADDR,
        DDATA,
        DSEND,
        DWAIT
    } dbg_state_t;

endpackage

// File: rtl/dump_sequencer.sv
// Streams N_DUMP state-dump bytes through the UART transmitter.
// Ports: go starts a dump at index send_counter; timeout_go sends the single
// timeout marker byte instead; clear zeroes send_counter/sent_flag;
// dump_addr/dump_data is the dump read port (data one cycle after address);
// tx_start/tx_data/tx_done is the transmitter handshake; done_c pulses
// (combinationally) on the edge that finishes the reply.
module dump_sequencer
    import debug_pkg::*;
#(
    parameter int unsigned N_DUMP = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic              timeout_go,
    input  logic              clear,
    input  logic              tx_done,
    input  logic [BYTE_W-1:0] dump_data,
    output logic [BYTE_W-1:0] dump_addr,
    output logic [BYTE_W-1:0] tx_data,
    output logic [BYTE_W-1:0] send_counter,
    output logic              tx_start,
    output logic              sent_flag,
    output logic              done_c
);

    localparam logic [BYTE_W-1:0] LAST_COUNT = BYTE_W'(N_DUMP);

    dbg_state_t        state, state_nxt;
    logic [BYTE_W-1:0] addr_nxt, data_nxt, cnt_nxt, cnt_inc;
    logic              start_nxt, sent_nxt;
    logic              tmo, tmo_nxt;

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            dump_addr    <= '0;
            tx_data      <= '0;
            send_counter <= '0;
            tx_start     <= 1'b0;
            sent_flag    <= 1'b0;
            tmo          <= 1'b0;
        end else begin
            state        <= state_nxt;
            dump_addr    <= addr_nxt;
            tx_data      <= data_nxt;
            send_counter <= cnt_nxt;
            tx_start     <= start_nxt;
            sent_flag    <= sent_nxt;
            tmo          <= tmo_nxt;
        end
    end

    // Next state and next register values
    always_comb begin
        state_nxt = state;
        addr_nxt  = dump_addr;
        data_nxt  = tx_data;
        cnt_nxt   = send_counter;
        start_nxt = 1'b0;
        sent_nxt  = sent_flag;
        tmo_nxt   = tmo;
        done_c    = 1'b0;
        cnt_inc   = send_counter + 8'd1;

        if (clear) begin
            cnt_nxt  = '0;
            sent_nxt = 1'b0;
        end

        case (state)
            IDLE: begin
                if (timeout_go) begin
                    // Timeout reply skips the dump read entirely
                    state_nxt = DSEND;
                    data_nxt  = DUMP_TIMEOUT_BYTE;
                    start_nxt = 1'b1;
                    tmo_nxt   = 1'b1;
                end else if (go) begin
                    state_nxt = DADDR;
                    addr_nxt  = send_counter;
                    tmo_nxt   = 1'b0;
                end
            end
            DADDR: state_nxt = DDATA;
            DDATA: begin
                data_nxt  = dump_data;
                start_nxt = 1'b1;
                state_nxt = DSEND;
            end
            DSEND: state_nxt = DWAIT;
            DWAIT: begin
                if (tx_done) begin
                    if (tmo) begin
                        cnt_nxt   = 8'd1;
                        sent_nxt  = 1'b1;
                        done_c    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == LAST_COUNT) begin
                            sent_nxt  = 1'b1;
                            done_c    = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            addr_nxt  = cnt_inc;
                            state_nxt = DADDR;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/debug_unit_ctrl.sv
// UART command sequencer for the processor datapath: decodes 'R' (reset),
// 'S' (step) and 'C' (run to halt), then streams a state dump back via
// dump_sequencer.
// Ports: clk/reset (async, active-high); rx_done/rx_data from the UART
// receiver; tx_start/tx_data/tx_done to the transmitter; dp_reset/dp_step/
// dp_halt to the datapath; dump_addr/dump_data dump read port; led_idle,
// sent_flag, send_counter board indicators.
// Build option: DEBUG_RUN_TIMEOUT_EN adds a run watchdog of TIMEOUT_CYC steps.
module debug_unit_ctrl
    import debug_pkg::*;
#(
    parameter int unsigned N_DUMP      = 16
`ifdef DEBUG_RUN_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 65535
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_done,
    input  logic [BYTE_W-1:0] rx_data,
    output logic              tx_start,
    output logic [BYTE_W-1:0] tx_data,
    input  logic              tx_done,
    output logic              dp_reset,
    output logic              dp_step,
    input  logic              dp_halt,
    output logic [BYTE_W-1:0] dump_addr,
    input  logic [BYTE_W-1:0] dump_data,
    output logic              led_idle,
    output logic              sent_flag,
    output logic [BYTE_W-1:0] send_counter
);

    dbg_state_t        state, state_nxt;
    logic [BYTE_W-1:0] cmd, cmd_nxt;
    logic              step_nxt, dprst_nxt;
    logic              go_c, tmo_go_c, clear_c, seq_done_c;

`ifdef DEBUG_RUN_TIMEOUT_EN
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] RUN_LIMIT = CNT_W'(TIMEOUT_CYC - 1);
    logic [CNT_W-1:0] run_cnt, run_cnt_nxt;

    // Counts step cycles issued in the current run
    always_ff @(posedge clk or posedge reset) begin
        if (reset) run_cnt <= '0;
        else       run_cnt <= run_cnt_nxt;
    end
`endif

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cmd      <= '0;
            dp_step  <= 1'b0;
            dp_reset <= 1'b0;
            led_idle <= 1'b1;
        end else begin
            state    <= state_nxt;
            cmd      <= cmd_nxt;
            dp_step  <= step_nxt;
            dp_reset <= dprst_nxt;
            led_idle <= (state_nxt == IDLE);
        end
    end

    // Decode/step/run control; dump phases are delegated and the top parks
    // in DADDR (or DSEND for a timeout reply) until the sequencer is done.
    always_comb begin
        state_nxt = state;
        cmd_nxt   = cmd;
        step_nxt  = 1'b0;
        dprst_nxt = 1'b0;
        go_c      = 1'b0;
        tmo_go_c  = 1'b0;
        clear_c   = 1'b0;
`ifdef DEBUG_RUN_TIMEOUT_EN
        run_cnt_nxt = run_cnt;
`endif

        case (state)
            IDLE: begin
                if (rx_done) begin
                    cmd_nxt   = rx_data;
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
`ifdef DEBUG_RUN_TIMEOUT_EN
                run_cnt_nxt = '0;
`endif
                case (cmd)
                    CMD_RESET: begin
                        clear_c   = 1'b1;
                        dprst_nxt = 1'b1;
                        state_nxt = DPRST;
                    end
                    CMD_STEP: begin
                        clear_c   = 1'b1;
                        step_nxt  = 1'b1;
                        state_nxt = STEP;
                    end
                    CMD_RUN: begin
                        // Already halted: enter RUN without issuing a step
                        clear_c   = 1'b1;
                        step_nxt  = ~dp_halt;
                        state_nxt = RUN;
                    end
                    default: state_nxt = IDLE;
                endcase
            end
            DPRST: state_nxt = IDLE;
            STEP: begin
                go_c      = 1'b1;
                state_nxt = DADDR;
            end
            RUN: begin
                if (dp_halt) begin
                    go_c      = 1'b1;
                    state_nxt = DADDR;
                end
`ifdef DEBUG_RUN_TIMEOUT_EN
                else if (dp_step && run_cnt == RUN_LIMIT) begin
                    tmo_go_c  = 1'b1;
                    state_nxt = DSEND;
                end else begin
                    step_nxt = 1'b1;
                    if (dp_step) run_cnt_nxt = run_cnt + 16'd1;
                end
`else
                else begin
                    step_nxt = 1'b1;
                end
`endif
            end
            default: begin
                if (seq_done_c) state_nxt = IDLE;
            end
        endcase
    end

    dump_sequencer #(
        .N_DUMP(N_DUMP)
    ) u_dump_sequencer (
        .clk          (clk),
        .reset        (reset),
        .go           (go_c),
        .timeout_go   (tmo_go_c),
        .clear        (clear_c),
        .tx_done      (tx_done),
        .dump_data    (dump_data),
        .dump_addr    (dump_addr),
        .tx_data      (tx_data),
        .send_counter (send_counter),
        .tx_start     (tx_start),
        .sent_flag    (sent_flag),
        .done_c       (seq_done_c)
    );

endmodule

// File: tb/tb_debug_unit_ctrl.sv
// Directed bench for debug_unit_ctrl with N_DUMP=4: a model transmitter
// answers each tx_start with tx_done, a registered dump memory returns
// base+addr, and monitors count step/reset/tx pulses.
module tb_debug_unit_ctrl;

    localparam int unsigned N = 4;

    logic       clk;
    logic       reset;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done;
    logic       dp_reset;
    logic       dp_step;
    logic       dp_halt;
    logic [7:0] dump_addr;
    logic [7:0] dump_data;
    logic       led_idle;
    logic       sent_flag;
    logic [7:0] send_counter;

    bit         auto_done;
    bit         halt_auto;
    logic       stray_done;
    logic       halt_pre;
    logic       halt_arm;
    int         halt_at;
    logic [7:0] dbase;
    int         step_cnt, rst_cnt, tx_cnt, tx_wait;
    logic [7:0] txq[$];
    int         n_checks, n_pass;

    assign tx_done = auto_done | stray_done;
    assign dp_halt = halt_auto | halt_pre;

    debug_unit_ctrl #(
        .N_DUMP(N)
`ifdef DEBUG_RUN_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(100)
`endif
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done      (rx_done),
        .rx_data      (rx_data),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_done      (tx_done),
        .dp_reset     (dp_reset),
        .dp_step      (dp_step),
        .dp_halt      (dp_halt),
        .dump_addr    (dump_addr),
        .dump_data    (dump_data),
        .led_idle     (led_idle),
        .sent_flag    (sent_flag),
        .send_counter (send_counter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Dump memory: data valid one cycle after the address
    always @(posedge clk) dump_data <= dbase + dump_addr;

    // Monitors, model transmitter and halt generator
    always @(negedge clk) begin
        auto_done = 1'b0;
        if (tx_wait > 0) begin
            tx_wait--;
            if (tx_wait == 0) auto_done = 1'b1;
        end
        if (tx_start === 1'b1) begin
            txq.push_back(tx_data);
            tx_cnt++;
            tx_wait = 3;
        end
        if (dp_reset === 1'b1) rst_cnt++;
        if (dp_step === 1'b1) step_cnt++;
        if (halt_arm !== 1'b1) halt_auto = 1'b0;
        else if (dp_step === 1'b1 && step_cnt == halt_at) halt_auto = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic send_cmd(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic wait_sent(input string tag);
        int n;
        n = 0;
        repeat (2) @(negedge clk);
        while (sent_flag !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(sent_flag), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_tx(input int target);
        int n;
        n = 0;
        while (tx_cnt < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (tx_cnt < target) check("wait_tx", 32'(tx_cnt), 32'(target));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_led_idle"}, 32'(led_idle), 32'd1);
        check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'h00);
        check({tag, "_dp_reset"}, 32'(dp_reset), 32'd0);
        check({tag, "_dp_step"}, 32'(dp_step), 32'd0);
        check({tag, "_dump_addr"}, 32'(dump_addr), 32'd0);
        check({tag, "_sent_flag"}, 32'(sent_flag), 32'd0);
        check({tag, "_send_counter"}, 32'(send_counter), 32'd0);
    endtask

    task automatic check_dump(input string tag, input int t0, input logic [7:0] base);
        for (int i = 0; i < int'(N); i++) begin
            if (t0 + i < txq.size()) check(tag, 32'(txq[t0+i]), 32'(base + 8'(i)));
            else check(tag, 32'hFFFF, 32'(base + 8'(i)));
        end
    endtask

    initial begin
        int s0, t0, r0;
        reset      = 1'b1;
        rx_done    = 1'b0;
        rx_data    = 8'h00;
        stray_done = 1'b0;
        halt_pre   = 1'b0;
        halt_arm   = 1'b0;
        halt_at    = 0;
        dbase      = 8'h10;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("post_rst");

        // Step: latency, one step pulse, four bytes 0x10..0x13
        s0 = step_cnt; t0 = tx_cnt;
        send_cmd(CMD_STEP_B());
        check("decode_busy", 32'(led_idle), 32'd0);
        @(negedge clk);
        check("step_lat", 32'(dp_step), 32'd1);
        @(negedge clk);
        check("step_one", 32'(dp_step), 32'd0);
        repeat (2) @(negedge clk);
        check("tx_first", 32'(tx_start), 32'd1);
        check("tx_first_data", 32'(tx_data), 32'h10);
        wait_sent("s_sent");
        check("s_steps", 32'(step_cnt - s0), 32'd1);
        check("s_txcnt", 32'(tx_cnt - t0), 32'd4);
        check_dump("s_byte", t0, 8'h10);
        check("s_counter", 32'(send_counter), 32'd4);
        check("s_idle", 32'(led_idle), 32'd1);

        // Unknown byte: nothing changes
        s0 = step_cnt; t0 = tx_cnt; r0 = rst_cnt;
        send_cmd(8'h41);
        repeat (10) @(negedge clk);
        check("x_sent", 32'(sent_flag), 32'd1);
        check("x_counter", 32'(send_counter), 32'd4);
        check("x_activity", 32'((step_cnt - s0) + (tx_cnt - t0) + (rst_cnt - r0)), 32'd0);
        check("x_idle", 32'(led_idle), 32'd1);

        // Run, halt raised after the 10th step
        s0 = step_cnt; t0 = tx_cnt;
        halt_at  = s0 + 10;
        halt_arm = 1'b1;
        dbase    = 8'h20;
        send_cmd(CMD_RUN_B());
        wait_sent("c_sent");
        check("c_steps", 32'(step_cnt - s0), 32'd10);
        check("c_txcnt", 32'(tx_cnt - t0), 32'd4);
        check_dump("c_byte", t0, 8'h20);
        check("c_counter", 32'(send_counter), 32'd4);
        halt_arm = 1'b0;

        // Run while already halted: zero steps, full dump
        s0 = step_cnt; t0 = tx_cnt;
        halt_pre = 1'b1;
        dbase    = 8'h30;
        send_cmd(CMD_RUN_B());
        wait_sent("h_sent");
        check("h_steps", 32'(step_cnt - s0), 32'd0);
        check("h_txcnt", 32'(tx_cnt - t0), 32'd4);
        check_dump("h_byte", t0, 8'h30);
        halt_pre = 1'b0;

        // Datapath reset: one pulse, no dump
        s0 = step_cnt; t0 = tx_cnt; r0 = rst_cnt;
        send_cmd(CMD_RESET_B());
        repeat (10) @(negedge clk);
        check("r_pulses", 32'(rst_cnt - r0), 32'd1);
        check("r_tx", 32'(tx_cnt - t0), 32'd0);
        check("r_steps", 32'(step_cnt - s0), 32'd0);
        check("r_sent", 32'(sent_flag), 32'd0);
        check("r_counter", 32'(send_counter), 32'd0);
        check("r_idle", 32'(led_idle), 32'd1);

        // Command during a dump is dropped
        s0 = step_cnt; t0 = tx_cnt;
        dbase = 8'h40;
        send_cmd(CMD_STEP_B());
        wait_tx(t0 + 1);
        send_cmd(CMD_STEP_B());
        wait_sent("d_sent");
        repeat (20) @(negedge clk);
        check("d_steps", 32'(step_cnt - s0), 32'd1);
        check("d_txcnt", 32'(tx_cnt - t0), 32'd4);
        check_dump("d_byte", t0, 8'h40);
        check("d_counter", 32'(send_counter), 32'd4);

        // Reset while waiting on the second byte
        t0 = tx_cnt;
        dbase = 8'h50;
        send_cmd(CMD_STEP_B());
        wait_tx(t0 + 2);
        @(negedge clk);
        #1 reset = 1'b1;
        #1 check_reset_values("mid_rst");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_no_tx", 32'(tx_cnt - t0), 32'd2);
        check("mid_idle", 32'(led_idle), 32'd1);
        check("mid_counter", 32'(send_counter), 32'd0);

`ifdef DEBUG_RUN_TIMEOUT_EN
        // Watchdog: 100 steps, then the single 0xEE reply
        s0 = step_cnt; t0 = tx_cnt;
        send_cmd(CMD_RUN_B());
        wait_sent("t_sent");
        check("t_steps", 32'(step_cnt - s0), 32'd100);
        check("t_txcnt", 32'(tx_cnt - t0), 32'd1);
        if (t0 < txq.size()) check("t_byte", 32'(txq[t0]), 32'hEE);
        else check("t_byte", 32'hFFFF, 32'hEE);
        check("t_counter", 32'(send_counter), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    function automatic logic [7:0] CMD_STEP_B();
        return 8'h53;
    endfunction

    function automatic logic [7:0] CMD_RUN_B();
        return 8'h43;
    endfunction

    function automatic logic [7:0] CMD_RESET_B();
        return 8'h52;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/debug_unit_ctrl.md
# debug_unit_ctrl

Command sequencer between the UART receiver/transmitter pair and the processor datapath. It decodes single-byte commands arriving on UART RX and then does one of three things: resets the datapath, steps it one clock, or runs it until halt. After a step or run it streams a fixed-length state dump, byte by byte, back through UART TX. It drives the board-visible idle/sent/counter indicators.

## Interface
- `N_DUMP`, default 16: number of dump bytes sent per step/run. Range 1..255.
- `TIMEOUT_CYC`, default 65535: run-mode watchdog limit (used only with `DEBUG_RUN_TIMEOUT_EN`).
- `clk` in 1: single clock, all state rises on posedge.
- `reset` in 1: asynchronous, active-high.
- `rx_done` in 1: one-cycle pulse, `rx_data` valid.
- `rx_data` in 8: received byte.
- `tx_start` out 1: one-cycle pulse, launch `tx_data`.
- `tx_data` out 8: byte to transmit; held stable until `tx_done`.
- `tx_done` in 1: one-cycle pulse, transmitter finished the byte.
- `dp_reset` out 1: one-cycle datapath reset pulse.
- `dp_step` out 1: datapath clock-enable. One cycle for step; continuous in run.
- `dp_halt` in 1: datapath has executed halt.
- `dump_addr` out 8: dump byte index.
- `dump_data` in 8: dump byte, valid one cycle after `dump_addr`.
- `led_idle` out 1: high in IDLE.
- `sent_flag` out 1: high from dump completion until the next accepted command.
- `send_counter` out 8: bytes sent in the current/last dump.

## Operation
- Command bytes:
  - 0x52 'R': datapath reset.
  - 0x53 'S': step.
  - 0x43 'C': continuous run.
  - Any other byte: ignored, stay IDLE.
- States: IDLE, DECODE, DPRST, STEP, RUN, DADDR, DDATA, DSEND, DWAIT.
- IDLE:
  - On `rx_done`, latch `rx_data` and go to DECODE.
  - `rx_done` in any other state is dropped.
- DECODE:
  - 'R' → DPRST.
  - 'S' → STEP.
  - 'C' → RUN.
  - Other → IDLE.
  - Clears `sent_flag` and `send_counter` for R/S/C.
- DPRST: `dp_reset`=1 for one cycle → IDLE. No dump is sent.
- STEP: `dp_step`=1 for one cycle → DADDR.
- RUN:
  - `dp_step`=1 while in RUN.
  - When `dp_halt`=1, deassert `dp_step` that same cycle and go to DADDR.
  - If `dp_halt` is already 1 on entry, zero steps are issued.
- DADDR: drive `dump_addr`=`send_counter` → DDATA.
- DDATA: register `dump_data` into `tx_data` → DSEND.
- DSEND: `tx_start`=1 for one cycle → DWAIT.
- DWAIT:
  - On `tx_done`, increment `send_counter`.
  - If the new count equals `N_DUMP`, set `sent_flag` and go to IDLE; otherwise go to DADDR.
- `tx_done` outside DWAIT is ignored.
- `send_counter` never wraps; its maximum is `N_DUMP`.

## Timing
- Reset values:
  - State IDLE.
  - `led_idle`=1.
  - `tx_start`=0, `tx_data`=0x00.
  - `dp_reset`=0, `dp_step`=0.
  - `dump_addr`=0.
  - `sent_flag`=0, `send_counter`=0.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous). Any dump in progress is abandoned. No `tx_start` is issued afterwards until a new command arrives.
- All outputs are registered.
- Latencies from `rx_done` sampled at edge k:
  - DECODE during cycle k+1.
  - `dp_step` or `dp_reset` high during cycle k+2.
  - Step: first `dump_addr` at k+3, first `tx_start` at k+5.
- Per byte, from `tx_done` to the next `tx_start`: 3 cycles.
- Run: `dp_step` falls the cycle after `dp_halt` is sampled. At most one extra step may be issued after halt; the datapath ignores steps while halted.

## Configuration
- `DEBUG_RUN_TIMEOUT_EN` defined:
  - A 16-bit counter runs in RUN.
  - At `TIMEOUT_CYC` steps without halt, leave RUN and go to DSEND with `tx_data`=0xEE. That single byte is the whole reply: `send_counter`=1, `sent_flag`=1, then IDLE.
- Undefined: RUN waits for `dp_halt` indefinitely. No counter logic is synthesized.

## Structure
- Shared package `debug_pkg` holds:
  - Command byte constants `CMD_RESET`, `CMD_STEP`, `CMD_RUN`.
  - Timeout marker `DUMP_TIMEOUT_BYTE` (0xEE).
  - State enum `dbg_state_t`.
- One natural sub-module: `dump_sequencer`, covering DADDR/DDATA/DSEND/DWAIT, the byte counter and the tx handshake. It is started by a `go` pulse and returns a `done` pulse. Decode, step and run stay in the top FSM.

## Test plan
- Reset, then `rx_done` with 0x53 and `N_DUMP`=4, dump bytes 0x10..0x13 → exactly one `dp_step` cycle, then four `tx_start` pulses carrying 0x10, 0x11, 0x12, 0x13; `send_counter`=4; `sent_flag`=1; `led_idle`=1.
- 0x43 with `dp_halt` rising after 10 cycles → `dp_step` high 10–11 cycles, then a full dump. With `dp_halt` already high on entry → 0 step cycles, then the dump.
- 0x52 → a single `dp_reset` pulse, no `tx_start`, `sent_flag` stays 0. Byte 0x41 → no outputs change.
- `rx_done` with 0x53 pulsed during an active dump → ignored; dump byte count is unchanged; no extra `dp_step`.
- `reset` asserted while in DWAIT at byte 2 → all outputs go to reset values immediately; a stray `tx_done` afterwards causes no `tx_start`.
- With `DEBUG_RUN_TIMEOUT_EN` and `TIMEOUT_CYC`=100, 0x43 and `dp_halt` held low → after 100 step cycles, one `tx_start` with `tx_data`=0xEE; `send_counter`=1; `sent_flag`=1.
